rr_arbiter_8: RTL and testbench
===============================

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter: MAX_HOLD, default 15, maximum cycles one grant is held before forced release (legal 1..15).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  8  per-requester request, bit i = requester i.
REQ-005 Port: done  input  1  current owner releases the resource, sampled only in GRANT.
REQ-006 Port: gnt  output  8  one-hot grant, registered.
REQ-007 Port: gnt_id  output  3  binary index of current owner, registered.
REQ-008 Port: gnt_valid  output  1  high while any grant is active, registered.
REQ-009 Port: timeout  output  1  one-cycle pulse when a grant is forcibly released by MAX_HOLD.

Function
REQ-010 The block SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-011 Internal state SHALL comprise: state, 3-bit round-robin pointer ptr, 4-bit hold counter cnt, registered owner index.
REQ-012 In IDLE with req != 0, the block SHALL select the first set bit scanning ptr, ptr+1, ... ptr+7 (mod 8) and enter GRANT at the next edge.
REQ-013 Latency: gnt, gnt_id and gnt_valid SHALL assert exactly one cycle after the IDLE cycle in which req was sampled nonzero.
REQ-014 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0, gnt_valid = 0.
REQ-015 In GRANT, gnt SHALL equal 1 << gnt_id, and gnt_valid SHALL be 1; gnt SHALL never have more than one bit set.
REQ-016 On entering GRANT, cnt SHALL load 1; each further GRANT cycle without release SHALL increment cnt.
REQ-017 Release SHALL occur in a GRANT cycle when done = 1, or req[gnt_id] = 0, or cnt == MAX_HOLD.
REQ-018 On release, the next edge SHALL: return to IDLE, clear gnt/gnt_valid, set ptr = gnt_id + 1 (mod 8, 7 wraps to 0), clear cnt.
REQ-019 timeout SHALL pulse high for exactly the cycle after a release caused solely by cnt == MAX_HOLD (done = 0 and req[gnt_id] = 1).
REQ-020 Simultaneous done and cnt == MAX_HOLD SHALL count as a normal release, timeout = 0.
REQ-021 At least one IDLE cycle SHALL separate consecutive grants; no back-to-back grant handoff.
REQ-022 Changes of req bits other than req[gnt_id] during GRANT SHALL have no effect until the next IDLE.
REQ-023 gnt_id SHALL hold its last owner value in IDLE; only gnt_valid qualifies it.
REQ-024 done asserted in IDLE SHALL be ignored.
REQ-025 Fairness: with all 8 requests continuously high and done pulsed each grant, owners SHALL cycle 0,1,2,...,7,0 in order.

Reset
REQ-026 rst_n = 0 SHALL immediately, without a clock edge, force: state = IDLE, ptr = 0, cnt = 0, gnt = 8'h00, gnt_id = 3'd0, gnt_valid = 0, timeout = 0.
REQ-027 Reset asserted mid-GRANT SHALL drop the grant immediately; after rst_n rises, arbitration SHALL restart from ptr = 0.
REQ-028 The first edge with rst_n = 1 SHALL be treated as an IDLE cycle.

Verification
REQ-029 Reset then req = 8'h01 -> one cycle later gnt = 8'h01, gnt_id = 0, gnt_valid = 1; done pulse -> next cycle gnt = 0, ptr = 1.
REQ-030 req = 8'hFF held, done pulsed each grant -> gnt_id sequence 0,1,...,7,0, one IDLE cycle between grants, gnt always one-hot.
REQ-031 ptr = 6 (after owner 5 released), req = 8'b0010_0001 -> grant goes to requester 0 (wrap), not 5.
REQ-032 MAX_HOLD = 4, req = 8'h08 held, done = 0 -> gnt = 8'h08 for 4 cycles, then gnt = 0 with timeout = 1 for one cycle, then grant reissued to requester 3.
REQ-033 Owner 2 drops req[2] with done = 0 -> release next edge, timeout = 0, ptr = 3.
REQ-034 rst_n pulsed low mid-GRANT on requester 4 -> gnt = 0, gnt_valid = 0 asynchronously; after release with req = 8'h11 -> requester 0 granted first.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a single owner, a hold-time limit and a
// mandatory idle cycle between grants.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout,
  output logic       dbg_state,
  output logic [2:0] dbg_ptr,
  output logic [3:0] dbg_cnt
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_HOLD);

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] id_nxt;
  logic       timeout_nxt;
  logic       found;
  logic [2:0] pick_id;
  logic [2:0] idx;
  logic       hold_hit;
  logic       release_hit;

  // Scan ptr, ptr+1, ... ptr+7; 3-bit addition provides the wrap.
  always_comb begin
    found   = 1'b0;
    pick_id = ptr;
    idx     = ptr;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        found   = 1'b1;
        pick_id = idx;
      end
    end
  end

  assign hold_hit    = (cnt == MAX_CNT);
  assign release_hit = done | ~req[gnt_id] | hold_hit;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    id_nxt      = gnt_id;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          id_nxt    = pick_id;
          cnt_nxt   = 4'd1;
        end
      end
      GRANT: begin
        if (release_hit) begin
          state_nxt   = IDLE;
          ptr_nxt     = gnt_id + 3'd1;
          cnt_nxt     = 4'd0;
          // Only a pure hold-limit release counts as a forced timeout.
          timeout_nxt = hold_hit & ~done & req[gnt_id];
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      cnt       <= 4'd0;
      gnt_id    <= 3'd0;
      gnt       <= 8'h00;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      gnt_id    <= id_nxt;
      gnt       <= (state_nxt == GRANT) ? (8'h01 << id_nxt) : 8'h00;
      gnt_valid <= (state_nxt == GRANT);
      timeout   <= timeout_nxt;
    end
  end

  assign dbg_state = state;
  assign dbg_ptr   = ptr;
  assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 (MAX_HOLD = 4): the driver queues hand-computed
// post-edge expectations, a monitor pops and compares them after each rising edge.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  logic       dbg_state;
  logic [2:0] dbg_ptr;
  logic [3:0] dbg_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  // Expected word: {gnt, gnt_id, gnt_valid, timeout, ptr}
  logic [15:0] exp_q[$];
  string       name_q[$];

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr), .dbg_cnt(dbg_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pack(logic [7:0] g, logic [2:0] id, logic v,
                                       logic to, logic [2:0] p);
    return {g, id, v, to, p};
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got gnt=%h id=%0d valid=%b to=%b ptr=%0d, want gnt=%h id=%0d valid=%b to=%b ptr=%0d",
               name, act[15:8], act[7:5], act[4], act[3], act[2:0],
               exp[15:8], exp[7:5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  // Monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(), pack(gnt, gnt_id, gnt_valid, timeout, dbg_ptr),
            exp_q.pop_front());
    end
  end

  // Driver: apply one cycle of inputs and queue the state expected after the edge.
  task automatic step(string name, logic [7:0] r, logic d,
                      logic [7:0] eg, logic [2:0] eid, logic ev, logic eto, logic [2:0] ep);
    @(negedge clk);
    req  = r;
    done = d;
    exp_q.push_back(pack(eg, eid, ev, eto, ep));
    name_q.push_back(name);
  endtask

  task automatic do_reset(string name);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    #1;
    check(name, pack(gnt, gnt_id, gnt_valid, timeout, dbg_ptr), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    #3;
    check("reset_state", pack(gnt, gnt_id, gnt_valid, timeout, dbg_ptr), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, done release, ptr advance, done ignored in IDLE
    step("single_grant",   8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 3'd0);
    step("single_done",    8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd1);
    step("idle_no_req",    8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 3'd1);
    step("idle_done_ign",  8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd1);

    // Fairness from ptr = 0 with every request held
    do_reset("reset_before_fair");
    for (int k = 0; k < 9; k++) begin
      step("fair_grant", 8'hFF, 1'b0, 8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0, 3'(k % 8));
      step("fair_idle",  8'hFF, 1'b1, 8'h00, 3'(k % 8), 1'b0, 1'b0, 3'((k + 1) % 8));
    end

    // Wrap: owner 5 released -> ptr 6, then req {5,0} goes to 0
    step("wrap_own5",      8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 3'd1);
    step("wrap_rel5",      8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0, 3'd6);
    step("wrap_grant0",    8'h21, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 3'd6);
    step("wrap_rel0",      8'h21, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd1);

    // Hold limit of 4 cycles forces release with a timeout pulse, then regrant
    step("to_grant",       8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 3'd1);
    step("to_hold2",       8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 3'd1);
    step("to_hold3",       8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 3'd1);
    step("to_hold4",       8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 3'd1);
    step("to_pulse",       8'h08, 1'b0, 8'h00, 3'd3, 1'b0, 1'b1, 3'd4);
    step("to_regrant",     8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 3'd4);

    // Other req bits moving during GRANT are ignored; done at the limit is no timeout
    step("hold_other_a",   8'h0F, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 3'd4);
    step("hold_other_b",   8'hFF, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 3'd4);
    step("hold_other_c",   8'h18, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0, 3'd4);
    step("done_at_limit",  8'h08, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 3'd4);

    // Owner drops its request
    step("drop_grant2",    8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0, 3'd4);
    step("drop_release",   8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 3'd3);
    step("drop_idle",      8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 3'd3);

    // Async reset mid-GRANT, then arbitration restarts from ptr 0
    step("pre_rst_grant4", 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, 3'd3);
    do_reset("async_rst_mid_grant");
    step("post_rst_own0",  8'h11, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 3'd0);
    step("post_rst_rel0",  8'h11, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 3'd1);
    step("post_rst_own4",  8'h11, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0, 3'd1);
    step("post_rst_rel4",  8'h00, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, 3'd5);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog");
  end

endmodule
